battleship_gen: RTL and testbench

- Parametrised second-generation two-player battleship game controller for the board-level game top.
- Inputs: player coordinate switches and per-player buttons. Outputs: four 7-segment digit patterns and an 8-bit LED bar.
- Beyond the fixed 4x4 / 4-ship / best-of-3 predecessor, it generalises grid size, ship count, match length and display timing.
- It also adds:
  - button edge detection;
  - per-player shot-history masks, so repeat shots are rejected;
  - an explicit match-over status.

---
 rtl/battleship_gen.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_battleship_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battleship_gen.sv
// battleship_gen -- two-player battleship game controller.
// Each player places SHIPS ships on a 2^CW x 2^CW grid. The players then take
// turns shooting until one of them sinks every enemy ship. The first player to
// win WIN_GAMES rounds wins the match.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          level; leaves IDLE
//   X, Y           column / row coordinate of the current cell
//   pAb, pBb       player buttons (levels; only rising edges act)
//   disp3..disp0   7-segment patterns (gfedcba in [6:0], dp = 0)
//   led            status LED bar
//   match_over     high once the match has been decided
//   winner         0 = A, 1 = B (valid with match_over)
module battleship_gen #(
  parameter int CW        = 2,
  parameter int SHIPS     = 4,
  parameter int WIN_GAMES = 2,
  parameter int MSG_TICKS = 30,
  parameter int RES_TICKS = 50,
  parameter int RND_TICKS = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          pAb,
  input  logic          pBb,
  output logic [7:0]    disp0,
  output logic [7:0]    disp1,
  output logic [7:0]    disp2,
  output logic [7:0]    disp3,
  output logic [7:0]    led,
  output logic          match_over,
  output logic          winner
);

  localparam int IW   = 2 * CW;
  localparam int NC   = 1 << IW;
  localparam int MAXT = (RND_TICKS > RES_TICKS) ?
                        ((RND_TICKS > MSG_TICKS) ? RND_TICKS : MSG_TICKS) :
                        ((RES_TICKS > MSG_TICKS) ? RES_TICKS : MSG_TICKS);
  localparam int TW   = $clog2(MAXT + 1) + 1;

  typedef enum logic [4:0] {
    IDLE, SHOW_A, A_IN, ERR_A, SHOW_B, B_IN, ERR_B, SHOW_SCORE,
    A_SHOOT, A_RES, B_SHOOT, B_RES, A_WIN, B_WIN, ROUND_SCORE,
    GAME_OVER, GAME_OVER1
  } state_t;

  localparam logic [7:0] L_A   = 8'h77;
  localparam logic [7:0] L_B   = 8'h7C;
  localparam logic [7:0] DASH  = 8'h40;

  state_t          state_q;
  logic [TW-1:0]   timer_q;
  logic [IW-1:0]   idx_q;
  logic [NC-1:0]   map_a_q, map_b_q, shot_a_q, shot_b_q;
  logic [3:0]      cnt_a_q, cnt_b_q, s_a_q, s_b_q;
  logic [2:0]      g_a_q, g_b_q;
  logic            starter_q;    // 0 = A started the round, 1 = B
  logic            winner_q;
  logic            hit_q;        // result of the last shot, shown in *_RES
  logic            err_shoot_q;  // ERR_x returns to *_SHOOT (1) or *_IN (0)
  logic            pab_q, pbb_q;

  logic            pa_fire_s, pb_fire_s, timed_s, tdone_s;
  logic [31:0]     lim_s;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'h3F;  4'h1: hex7 = 8'h06;  4'h2: hex7 = 8'h5B;  4'h3: hex7 = 8'h4F;
      4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'h6D;  4'h6: hex7 = 8'h7D;  4'h7: hex7 = 8'h07;
      4'h8: hex7 = 8'h7F;  4'h9: hex7 = 8'h6F;  4'hA: hex7 = 8'h77;  4'hB: hex7 = 8'h7C;
      4'hC: hex7 = 8'h39;  4'hD: hex7 = 8'h5E;  4'hE: hex7 = 8'h79;  4'hF: hex7 = 8'h71;
      default: hex7 = 8'h00;
    endcase
  endfunction

  assign pa_fire_s = pAb & ~pab_q;
  assign pb_fire_s = pBb & ~pbb_q;

  // Hold time of the current state; untimed states keep the timer at zero.
  always_comb begin
    timed_s = 1'b1;
    lim_s   = 32'd0;
    case (state_q)
      SHOW_A, SHOW_B, ERR_A, ERR_B:                 lim_s = 32'(MSG_TICKS);
      SHOW_SCORE, A_RES, B_RES, A_WIN, B_WIN,
      GAME_OVER, GAME_OVER1:                        lim_s = 32'(RES_TICKS);
      ROUND_SCORE:                                  lim_s = 32'(RND_TICKS);
      default:                                      timed_s = 1'b0;
    endcase
    tdone_s = timed_s && (32'(timer_q) == lim_s);
  end

  // Game FSM and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      map_a_q     <= '0;
      map_b_q     <= '0;
      shot_a_q    <= '0;
      shot_b_q    <= '0;
      cnt_a_q     <= 4'd0;
      cnt_b_q     <= 4'd0;
      s_a_q       <= 4'd0;
      s_b_q       <= 4'd0;
      g_a_q       <= 3'd0;
      g_b_q       <= 3'd0;
      starter_q   <= 1'b0;
      winner_q    <= 1'b0;
      hit_q       <= 1'b0;
      err_shoot_q <= 1'b0;
      pab_q       <= 1'b0;
      pbb_q       <= 1'b0;
    end else begin
      pab_q <= pAb;
      pbb_q <= pBb;
      idx_q <= {Y, X};
      // Every timed state leaves exactly when the timer expires, so the
      // timer can wrap to zero here without per-transition clears.
      if (timed_s) timer_q <= tdone_s ? '0 : timer_q + TW'(1);

      case (state_q)
        IDLE: if (start) begin
          starter_q <= 1'b0;
          state_q   <= SHOW_A;
        end
        SHOW_A: if (tdone_s) state_q <= A_IN;
        SHOW_B: if (tdone_s) state_q <= B_IN;
        ERR_A:  if (tdone_s) state_q <= err_shoot_q ? A_SHOOT : A_IN;
        ERR_B:  if (tdone_s) state_q <= err_shoot_q ? B_SHOOT : B_IN;
        A_IN: if (pa_fire_s) begin
          if (map_a_q[idx_q]) begin
            err_shoot_q <= 1'b0;
            state_q     <= ERR_A;
          end else begin
            map_a_q[idx_q] <= 1'b1;
            cnt_a_q        <= cnt_a_q + 4'd1;
            if (cnt_a_q + 4'd1 == 4'(SHIPS)) state_q <= starter_q ? SHOW_SCORE : SHOW_B;
          end
        end
        B_IN: if (pb_fire_s) begin
          if (map_b_q[idx_q]) begin
            err_shoot_q <= 1'b0;
            state_q     <= ERR_B;
          end else begin
            map_b_q[idx_q] <= 1'b1;
            cnt_b_q        <= cnt_b_q + 4'd1;
            if (cnt_b_q + 4'd1 == 4'(SHIPS)) state_q <= starter_q ? SHOW_A : SHOW_SCORE;
          end
        end
        SHOW_SCORE: if (tdone_s) state_q <= starter_q ? B_SHOOT : A_SHOOT;
        A_SHOOT: if (pa_fire_s) begin
          if (shot_a_q[idx_q]) begin
            err_shoot_q <= 1'b1;
            state_q     <= ERR_A;
          end else begin
            shot_a_q[idx_q] <= 1'b1;
            hit_q           <= map_b_q[idx_q];
            if (map_b_q[idx_q]) begin
              map_b_q[idx_q] <= 1'b0;
              s_a_q          <= s_a_q + 4'd1;
            end
            state_q <= A_RES;
          end
        end
        B_SHOOT: if (pb_fire_s) begin
          if (shot_b_q[idx_q]) begin
            err_shoot_q <= 1'b1;
            state_q     <= ERR_B;
          end else begin
            shot_b_q[idx_q] <= 1'b1;
            hit_q           <= map_a_q[idx_q];
            if (map_a_q[idx_q]) begin
              map_a_q[idx_q] <= 1'b0;
              s_b_q          <= s_b_q + 4'd1;
            end
            state_q <= B_RES;
          end
        end
        A_RES: if (tdone_s) state_q <= (s_a_q == 4'(SHIPS)) ? A_WIN : B_SHOOT;
        B_RES: if (tdone_s) state_q <= (s_b_q == 4'(SHIPS)) ? B_WIN : A_SHOOT;
        A_WIN: if (tdone_s) begin
          g_a_q     <= g_a_q + 3'd1;
          starter_q <= 1'b0;
          if (g_a_q + 3'd1 == 3'(WIN_GAMES)) begin
            winner_q <= 1'b0;
            state_q  <= GAME_OVER;
          end else begin
            state_q  <= ROUND_SCORE;
          end
        end
        B_WIN: if (tdone_s) begin
          g_b_q     <= g_b_q + 3'd1;
          starter_q <= 1'b1;
          if (g_b_q + 3'd1 == 3'(WIN_GAMES)) begin
            winner_q <= 1'b1;
            state_q  <= GAME_OVER;
          end else begin
            state_q  <= ROUND_SCORE;
          end
        end
        ROUND_SCORE: if (tdone_s) begin
          map_a_q  <= '0;
          map_b_q  <= '0;
          shot_a_q <= '0;
          shot_b_q <= '0;
          s_a_q    <= 4'd0;
          s_b_q    <= 4'd0;
          cnt_a_q  <= 4'd0;
          cnt_b_q  <= 4'd0;
          state_q  <= starter_q ? SHOW_B : SHOW_A;
        end
        GAME_OVER:  if (tdone_s) state_q <= GAME_OVER1;
        GAME_OVER1: if (tdone_s) state_q <= GAME_OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display / LED decode of the registered state.
  always_comb begin
    disp3 = 8'h00;
    disp2 = 8'h00;
    disp1 = 8'h00;
    disp0 = 8'h00;
    led   = 8'h00;
    case (state_q)
      IDLE: begin
        disp3 = 8'h06; disp2 = 8'h5E; disp1 = 8'h38; disp0 = 8'h79; led = 8'h99;
      end
      SHOW_A: begin disp3 = L_A; led = 8'h99; end
      SHOW_B: begin disp3 = L_B; led = 8'h99; end
      ERR_A, ERR_B: begin
        disp3 = 8'h79; disp2 = 8'h50; disp1 = 8'h50; disp0 = 8'h5C;
      end
      A_IN: begin
        disp1 = hex7(4'(X)); disp0 = hex7(4'(Y));
        led   = {1'b1, 1'b0, cnt_a_q[1:0], 4'b0000};
      end
      B_IN: begin
        disp1 = hex7(4'(X)); disp0 = hex7(4'(Y));
        led   = {4'b0000, cnt_b_q[1:0], 1'b0, 1'b1};
      end
      A_SHOOT: begin
        disp1 = hex7(4'(X)); disp0 = hex7(4'(Y));
        led   = {1'b1, s_a_q[2:0], s_b_q[2:0], 1'b0};
      end
      B_SHOOT: begin
        disp1 = hex7(4'(X)); disp0 = hex7(4'(Y));
        led   = {1'b0, s_a_q[2:0], s_b_q[2:0], 1'b1};
      end
      A_RES, B_RES: begin
        disp2 = hex7(s_a_q); disp1 = DASH; disp0 = hex7(s_b_q);
        led   = hit_q ? 8'hFF : 8'h00;
      end
      A_WIN, B_WIN: begin
        disp3 = (state_q == A_WIN) ? L_A : L_B;
        disp2 = hex7(s_a_q); disp1 = DASH; disp0 = hex7(s_b_q);
        led   = 8'hAA;
      end
      SHOW_SCORE: begin
        disp2 = hex7({1'b0, g_a_q}); disp1 = DASH; disp0 = hex7({1'b0, g_b_q});
        led   = 8'hAA;
      end
      ROUND_SCORE: begin
        disp3 = starter_q ? L_B : L_A;
        disp2 = hex7({1'b0, g_a_q}); disp1 = DASH; disp0 = hex7({1'b0, g_b_q});
        led   = 8'hAA;
      end
      GAME_OVER, GAME_OVER1: begin
        disp3 = winner_q ? L_B : L_A;
        disp2 = hex7({1'b0, g_a_q}); disp1 = DASH; disp0 = hex7({1'b0, g_b_q});
        led   = (state_q == GAME_OVER) ? 8'hAA : 8'h55;
      end
      default: led = 8'h00;
    endcase
  end

  assign match_over = (state_q == GAME_OVER) || (state_q == GAME_OVER1);
  assign winner     = winner_q;

endmodule

// File: tb/tb_battleship_gen.sv
// tb_battleship_gen -- directed self-checking bench for battleship_gen.
// u_dut runs the default configuration; u_dut5 (CW=3, SHIPS=2, WIN_GAMES=1)
// shares the buttons, start and reset, but it has its own coordinates.
module tb_battleship_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pAb = 1'b0;
  logic       pBb = 1'b0;
  logic [1:0] X = 2'd0, Y = 2'd0;
  logic [2:0] X5 = 3'd0, Y5 = 3'd0;
  logic [7:0] d0, d1, d2, d3, led;
  logic [7:0] e0, e1, e2, e3, led5;
  logic       mo, win, mo5, win5;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk = ~clk;

  battleship_gen u_dut (
    .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .pAb(pAb), .pBb(pBb),
    .disp0(d0), .disp1(d1), .disp2(d2), .disp3(d3), .led(led),
    .match_over(mo), .winner(win)
  );

  battleship_gen #(.CW(3), .SHIPS(2), .WIN_GAMES(1)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .X(X5), .Y(Y5), .pAb(pAb), .pBb(pBb),
    .disp0(e0), .disp1(e1), .disp2(e2), .disp3(e3), .led(led5),
    .match_over(mo5), .winner(win5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_xy(input logic [1:0] x, input logic [1:0] y);
    X = x;
    Y = y;
    tick();
  endtask

  task automatic press_a();
    pAb = 1'b1;
    tick();
    pAb = 1'b0;
  endtask

  task automatic press_b();
    pBb = 1'b1;
    tick();
    pBb = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_d3"}, d3, 8'h06);
    chk({tag, "_d2"}, d2, 8'h5E);
    chk({tag, "_d1"}, d1, 8'h38);
    chk({tag, "_d0"}, d0, 8'h79);
    chk({tag, "_led"}, led, 8'h99);
    chk({tag, "_mo"}, mo, 1'b0);
  endtask

  // A ships and B ships (X,Y), and B's missing shots
  int ax [4] = '{1, 2, 3, 0};
  int ay [4] = '{2, 1, 3, 3};
  int bx [4] = '{1, 2, 3, 0};
  int by [4] = '{1, 2, 0, 2};
  int mx [3] = '{1, 2, 3};
  int my [3] = '{0, 0, 1};

  initial begin
    int n;
    // ---- 1: reset defaults and SHOW_A length
    ticks(2);
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_win", win, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (d3 == 8'h77 && n < 200) begin n++; tick(); end
    chk("show_a_len", n, 31);
    chk("a_in_led", led, 8'h80);

    // ---- 2: duplicate placement and held button
    set_xy(2'd1, 2'd2);
    chk("a_in_d1", d1, 8'h06);
    chk("a_in_d0", d0, 8'h5B);
    press_a();
    chk("place1_led", led, 8'h90);
    set_xy(2'd1, 2'd2);
    press_a();
    chk("erra_d3", d3, 8'h79);
    chk("erra_d2", d2, 8'h50);
    chk("erra_d1", d1, 8'h50);
    chk("erra_d0", d0, 8'h5C);
    n = 0;
    while (d3 == 8'h79 && n < 200) begin n++; tick(); end
    chk("erra_len", n, 31);
    chk("after_err_cnt", led, 8'h90);
    set_xy(2'd2, 2'd1);
    pAb = 1'b1;
    ticks(20);
    pAb = 1'b0;
    tick();
    chk("held_once", led, 8'hA0);
    set_xy(2'(ax[2]), 2'(ay[2]));
    press_a();
    chk("place3_led", led, 8'hB0);
    set_xy(2'(ax[3]), 2'(ay[3]));
    press_a();
    chk("show_b_d3", d3, 8'h7C);
    chk("show_b_led", led, 8'h99);
    ticks(31);
    chk("b_in_led", led, 8'h01);
    for (int i = 0; i < 4; i++) begin
      set_xy(2'(bx[i]), 2'(by[i]));
      press_b();
      if (i < 3) chk("b_place_led", led, 32'((i + 1) * 4 + 1));
    end
    chk("score_d2", d2, 8'h3F);
    chk("score_d1", d1, 8'h40);
    chk("score_d0", d0, 8'h3F);
    chk("score_led", led, 8'hAA);
    ticks(51);
    chk("a_shoot_led", led, 8'h80);

    // ---- 3: miss then repeat shot
    set_xy(2'd0, 2'd0);
    press_a();
    chk("a_miss_led", led, 8'h00);
    chk("a_miss_d2", d2, 8'h3F);
    ticks(51);
    chk("b_shoot_led", led, 8'h01);
    set_xy(2'd0, 2'd0);
    press_b();
    chk("b_miss_led", led, 8'h00);
    ticks(51);
    chk("back_a_shoot", led, 8'h80);
    set_xy(2'd0, 2'd0);
    press_a();
    chk("repeat_err", d3, 8'h79);
    ticks(31);
    chk("repeat_back", led, 8'h80);
    set_xy(2'd1, 2'd1);
    press_b();
    chk("pb_ignored", led, 8'h80);

    // ---- 4: A sinks all four B ships
    for (int k = 1; k <= 4; k++) begin
      set_xy(2'(bx[k-1]), 2'(by[k-1]));
      press_a();
      chk("hit_led", led, 8'hFF);
      chk("hit_d2", d2, HEX[k]);
      ticks(51);
      if (k < 4) begin
        chk("b_turn_led", led, 32'((k << 4) | 1));
        set_xy(2'(mx[k-1]), 2'(my[k-1]));
        press_b();
        chk("b_miss2_led", led, 8'h00);
        ticks(51);
      end
    end
    chk("awin_d3", d3, 8'h77);
    chk("awin_led", led, 8'hAA);
    chk("awin_d2", d2, 8'h66);
    ticks(51);
    chk("rnd_d3", d3, 8'h77);
    chk("rnd_d2", d2, 8'h06);
    chk("rnd_d1", d1, 8'h40);
    chk("rnd_d0", d0, 8'h3F);
    chk("rnd_mo", mo, 1'b0);
    ticks(101);
    chk("r2_show_a", d3, 8'h77);
    ticks(31);
    chk("r2_a_in_led", led, 8'h80);

    // ---- 6: round two up to B_SHOOT, then reset
    for (int i = 0; i < 4; i++) begin
      set_xy(2'(ax[i]), 2'(ay[i]));
      press_a();
      if (i < 3) chk("r2_a_place", led, 32'(8'h80 | ((i + 1) << 4)));
    end
    chk("r2_show_b", d3, 8'h7C);
    ticks(31);
    for (int i = 0; i < 4; i++) begin
      set_xy(2'(bx[i]), 2'(by[i]));
      press_b();
      if (i < 3) chk("r2_b_place", led, 32'((i + 1) * 4 + 1));
    end
    chk("r2_score_d2", d2, 8'h06);
    chk("r2_score_d0", d0, 8'h3F);
    ticks(51);
    chk("r2_a_shoot", led, 8'h80);
    set_xy(2'd0, 2'd0);
    press_a();
    chk("r2_shot_ok_d3", d3, 8'h00);
    chk("r2_shot_ok_led", led, 8'h00);
    ticks(51);
    chk("r2_b_shoot", led, 8'h01);
    rst = 1'b1;
    tick();
    chk_idle("midrst");
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(31);
    chk("fresh_a_in", led, 8'h80);
    for (int i = 0; i < 4; i++) begin
      set_xy(2'(ax[i]), 2'(ay[i]));
      press_a();
      if (i < 3) chk("fresh_place", led, 32'(8'h80 | ((i + 1) << 4)));
    end
    chk("fresh_show_b", d3, 8'h7C);

    // ---- 5: CW=3, SHIPS=2, WIN_GAMES=1 on u_dut5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(31);
    X5 = 3'd7; Y5 = 3'd7; tick();
    chk("p5_d1", e1, 8'h07);
    chk("p5_d0", e0, 8'h07);
    press_a();
    chk("p5_place1", led5, 8'h90);
    X5 = 3'd5; Y5 = 3'd6; tick();
    press_a();
    chk("p5_show_b", e3, 8'h7C);
    ticks(31);
    X5 = 3'd7; Y5 = 3'd7; tick();
    press_b();
    X5 = 3'd5; Y5 = 3'd6; tick();
    press_b();
    chk("p5_score_led", led5, 8'hAA);
    ticks(51);
    X5 = 3'd0; Y5 = 3'd0; tick();
    press_a();
    chk("p5_a_miss", led5, 8'h00);
    ticks(51);
    X5 = 3'd7; Y5 = 3'd7; tick();
    press_b();
    chk("p5_b_hit1", led5, 8'hFF);
    chk("p5_b_hit1_d0", e0, 8'h06);
    ticks(51);
    X5 = 3'd1; Y5 = 3'd0; tick();
    press_a();
    chk("p5_a_miss2", led5, 8'h00);
    ticks(51);
    X5 = 3'd5; Y5 = 3'd6; tick();
    press_b();
    chk("p5_b_hit2_d0", e0, 8'h5B);
    ticks(51);
    chk("p5_bwin_d3", e3, 8'h7C);
    chk("p5_bwin_mo", mo5, 1'b0);
    ticks(51);
    chk("p5_go_mo", mo5, 1'b1);
    chk("p5_go_win", win5, 1'b1);
    chk("p5_go_d3", e3, 8'h7C);
    chk("p5_go_d2", e2, 8'h3F);
    chk("p5_go_d0", e0, 8'h06);
    n = 0;
    while (led5 == 8'hAA && n < 200) begin n++; tick(); end
    chk("p5_aa_len", n, 51);
    chk("p5_led55", led5, 8'h55);
    n = 0;
    while (led5 == 8'h55 && n < 200) begin n++; tick(); end
    chk("p5_55_len", n, 51);
    chk("p5_ledaa", led5, 8'hAA);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("p5_start_ignored", mo5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
